result_quantizer: RTL

Writeback stage downstream of the vector engine. On a start pulse (driven by the frame controller's frame-done) it snapshots the LANES×32-bit accumulator vector, quantizes each lane to a trit against a programmable threshold, packs trits PT-5 (5 trits/byte, 3 bytes per 24-bit word), and streams the words with a valid/ready handshake to the SRAM write port. This closes the loop so that layer outputs become the next frame's inputs without a host round trip.

---
 rtl/fabric_pkg.sv | 18 +
 rtl/result_quantizer_if.sv | 10 +
 rtl/pt5_packer.sv | 26 ++
 rtl/result_quantizer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/fabric_pkg.sv
// Shared definitions for the trit writeback path: trit codes, PT-5 geometry
// and the quantizer FSM state encoding.
package fabric_pkg;
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;

  localparam int TRITS_PER_BYTE = 5;
  localparam int BYTES_PER_WORD = 3;
  localparam int TRITS_PER_WORD = TRITS_PER_BYTE * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/result_quantizer_if.sv
// Valid/ready word port from the quantizer to the SRAM write side.
interface result_quantizer_if #(parameter int ADDR_WIDTH = 12);
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [23:0]           wb_data;

  modport master (output wb_valid, output wb_addr, output wb_data, input  wb_ready);
  modport slave  (input  wb_valid, input  wb_addr, input  wb_data, output wb_ready);
endinterface

// File: rtl/pt5_packer.sv
// Combinational PT-5 packer: five trit codes to one base-3 byte, digit = trit+1.
module pt5_packer
  import fabric_pkg::*;
(
  input  logic [TRITS_PER_BYTE-1:0][1:0] trits_i,
  output logic [7:0]                     byte_o
);
  logic [7:0] sum, w, d;

  always_comb begin
    sum = '0;
    w   = 8'd1;
    d   = 8'd1;
    for (int j = 0; j < TRITS_PER_BYTE; j++) begin
      case (trits_i[j])
        TRIT_POS: d = 8'd2;
        TRIT_NEG: d = 8'd0;
        default:  d = 8'd1;
      endcase
      sum = sum + d * w;
      w   = w * 8'd3;
    end
  end

  assign byte_o = sum;
endmodule

// File: rtl/result_quantizer.sv
// Snapshot accumulators on start, quantize to trits, pack PT-5 and stream 24-bit words.
// Optional QUANT_STATS_EN adds nz_count, the nonzero-trit count of the last operation.
module result_quantizer
  import fabric_pkg::*;
#(
  parameter int LANES      = 15,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [LANES*ACC_WIDTH-1:0] acc_in,
  input  logic [ACC_WIDTH-1:0]       threshold,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  result_quantizer_if.master         wb,
  output logic                       busy,
  output logic                       done
`ifdef QUANT_STATS_EN
  ,output logic [15:0]               nz_count
`endif
);
  localparam int WORDS  = (LANES + TRITS_PER_WORD - 1) / TRITS_PER_WORD;
  localparam int NBITS  = WORDS * TRITS_PER_WORD * 2;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF_W  = $clog2(NBITS);

  logic [NBITS-1:0]      qtrit, trit_q, trit_d;
  state_t                state_q, state_d;
  logic [WIDX_W-1:0]     word_q, word_d;
  logic [1:0]            byte_q, byte_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [23:0]           data_q, data_d;
  logic [OFF_W-1:0]      pk_off;
  logic [2*TRITS_PER_BYTE-1:0] pk_trits;
  logic [7:0]            pk_byte;

  // Quantizing at capture time keeps only 2 bits per lane instead of the full accumulator.
  for (genvar i = 0; i < WORDS*TRITS_PER_WORD; i++) begin : g_lane
    if (i < LANES) begin : g_q
      logic signed [ACC_WIDTH:0] a, t;
      assign a = {acc_in[i*ACC_WIDTH + ACC_WIDTH - 1], acc_in[i*ACC_WIDTH +: ACC_WIDTH]};
      assign t = {1'b0, threshold};
      assign qtrit[2*i +: 2] = (a > t) ? TRIT_POS : (a < -t) ? TRIT_NEG : TRIT_ZERO;
    end else begin : g_pad
      assign qtrit[2*i +: 2] = TRIT_ZERO;
    end
  end

  assign pk_off   = OFF_W'(32'(word_q) * 2 * TRITS_PER_WORD + 32'(byte_q) * 2 * TRITS_PER_BYTE);
  assign pk_trits = trit_q[pk_off +: 2*TRITS_PER_BYTE];

  pt5_packer u_pack (.trits_i(pk_trits), .byte_o(pk_byte));

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    base_d  = base_q;
    data_d  = data_q;
    trit_d  = trit_q;
    case (state_q)
      ST_IDLE: if (start) begin
        trit_d  = qtrit;
        base_d  = base_addr;
        word_d  = '0;
        byte_d  = '0;
        state_d = ST_PACK;
      end
      ST_PACK: begin
        data_d[{byte_q, 3'b000} +: 8] = pk_byte;
        byte_d = byte_q + 2'd1;
        if (byte_q == 2'd2) begin
          byte_d  = '0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: if (wb.wb_ready) begin
        if (word_q == WIDX_W'(WORDS - 1)) state_d = ST_DONE;
        else begin
          word_d  = word_q + 1'b1;
          state_d = ST_PACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      base_q  <= '0;
      data_q  <= '0;
      trit_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      base_q  <= base_d;
      data_q  <= data_d;
      trit_q  <= trit_d;
    end
  end

  assign wb.wb_valid = (state_q == ST_EMIT);
  assign wb.wb_addr  = base_q + ADDR_WIDTH'(word_q);
  assign wb.wb_data  = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

`ifdef QUANT_STATS_EN
  logic [15:0] nz_q;
  logic [2:0]  pk_nz;

  always_comb begin
    pk_nz = '0;
    for (int j = 0; j < TRITS_PER_BYTE; j++)
      if (pk_trits[2*j +: 2] != TRIT_ZERO) pk_nz = pk_nz + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            nz_q <= '0;
    else if (state_q == ST_IDLE && start)    nz_q <= '0;
    else if (state_q == ST_PACK)             nz_q <= nz_q + 16'(pk_nz);
  end

  assign nz_count = nz_q;
`endif
endmodule
